// File: rtl/dbus_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dbus_ctrl_pkg : shared state encoding and byte-enable constants      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dbus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_NONE    = 4'b0000;

    localparam logic [31:0] DEF_DATA_BASE      = 32'h1001_0000;
    localparam logic [31:0] DEF_DATA_SIZE      = 32'h0000_2000;
    localparam int          DEF_TIMEOUT_CYCLES = 255;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dbus_ctrl_if : datapath-side and memory-side signals of dbus_ctrl    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dbus_ctrl_if;
    logic        dw_read_enable;
    logic        dw_write_enable;
    logic [3:0]  dw_byte_enable;
    logic [31:0] dw_address;
    logic [31:0] dw_write_data;
    logic [31:0] dw_read_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wr_data;
    logic        mem_ack;
    logic [31:0] mem_rd_data;
    logic        misaligned;
    logic        bus_error;
    logic [31:0] load_count;
    logic [31:0] store_count;

    // Controller side
    modport slave (
        input  dw_read_enable, dw_write_enable, dw_byte_enable, dw_address,
               dw_write_data, mem_ack, mem_rd_data,
        output dw_read_data, stall, mem_req, mem_we, mem_addr, mem_byte_en,
               mem_wr_data, misaligned, bus_error, load_count, store_count
    );

    // Datapath + memory environment side
    modport master (
        output dw_read_enable, dw_write_enable, dw_byte_enable, dw_address,
               dw_write_data, mem_ack, mem_rd_data,
        input  dw_read_data, stall, mem_req, mem_we, mem_addr, mem_byte_en,
               mem_wr_data, misaligned, bus_error, load_count, store_count
    );
endinterface
`default_nettype wire

// File: rtl/dbus_ctrl_access_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dbus_access_check : classifies an access as misaligned/out-of-range  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dbus_access_check
    import dbus_ctrl_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
    parameter logic [31:0] DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic [31:0] addr,
    input  logic [3:0]  byte_en,
    output logic        misaligned,
    output logic        out_of_range
);

    logic [31:0] w_offset;
    logic        w_half;

    always_comb begin
        w_offset   = addr - DATA_BASE;
        w_half     = (byte_en == BE_HALF_LO) || (byte_en == BE_HALF_HI);
        misaligned = ((byte_en == BE_WORD) && (addr[1:0] != 2'b00)) ||
                     (w_half && addr[0]);
        // Offset form avoids overflow when the region ends at the top of memory
        out_of_range = !misaligned &&
                       ((addr < DATA_BASE) || (w_offset >= DATA_SIZE));
    end

endmodule
`default_nettype wire

// File: rtl/dbus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dbus_ctrl : stalls the datapath and turns its data accesses into     |
// | req/ack memory transactions. Option macro: DBUS_TIMEOUT_EN. Rev 1.0  |
// +----------------------------------------------------------------------+
module dbus_ctrl
    import dbus_ctrl_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
    parameter logic [31:0] DATA_SIZE = DEF_DATA_SIZE
`ifdef DBUS_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic       clk,
    input  logic       rst,
    dbus_ctrl_if.slave bus
);

    state_t      r_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_byte_en;
    logic [31:0] r_mem_wr_data;
    logic [31:0] r_rd_data;
    logic        r_mis_flag;
    logic        r_err_flag;
    logic        r_done_ok;
    logic        r_done_we;
    logic [31:0] r_load_count;
    logic [31:0] r_store_count;

    logic w_req;
    logic w_we;
    logic w_misaligned;
    logic w_out_of_range;

`ifdef DBUS_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] r_wait_cnt;
`endif

    assign w_req = bus.dw_read_enable | bus.dw_write_enable;
    assign w_we  = bus.dw_write_enable;

    dbus_access_check #(
        .DATA_BASE (DATA_BASE),
        .DATA_SIZE (DATA_SIZE)
    ) u_check (
        .addr         (bus.dw_address),
        .byte_en      (bus.dw_byte_enable),
        .misaligned   (w_misaligned),
        .out_of_range (w_out_of_range)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_byte_en <= '0;
            r_mem_wr_data <= '0;
            r_rd_data     <= '0;
            r_mis_flag    <= 1'b0;
            r_err_flag    <= 1'b0;
            r_done_ok     <= 1'b0;
            r_done_we     <= 1'b0;
            r_load_count  <= '0;
            r_store_count <= '0;
`ifdef DBUS_TIMEOUT_EN
            r_wait_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (bus.dw_byte_enable == BE_NONE) begin
                            // No lanes selected: retires as a successful no-op
                            r_done_ok <= 1'b1;
                            r_done_we <= w_we;
                            r_rd_data <= '0;
                            r_state   <= ST_DONE;
                        end else if (w_misaligned) begin
                            r_mis_flag <= 1'b1;
                            r_rd_data  <= '0;
                            r_state    <= ST_DONE;
                        end else if (w_out_of_range) begin
                            r_err_flag <= 1'b1;
                            r_rd_data  <= '0;
                            r_state    <= ST_DONE;
                        end else begin
                            r_mem_req     <= 1'b1;
                            r_mem_we      <= w_we;
                            r_mem_addr    <= word_addr(bus.dw_address);
                            r_mem_byte_en <= bus.dw_byte_enable;
                            r_mem_wr_data <= bus.dw_write_data;
`ifdef DBUS_TIMEOUT_EN
                            r_wait_cnt    <= '0;
`endif
                            r_state       <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_rd_data <= r_mem_we ? 32'h0 : bus.mem_rd_data;
                        r_done_ok <= 1'b1;
                        r_done_we <= r_mem_we;
                        r_state   <= ST_DONE;
                    end
`ifdef DBUS_TIMEOUT_EN
                    else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_mem_req  <= 1'b0;
                        r_err_flag <= 1'b1;
                        r_rd_data  <= '0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    if (r_done_ok) begin
                        if (r_done_we) r_store_count <= r_store_count + 32'd1;
                        else           r_load_count  <= r_load_count + 32'd1;
                    end
                    r_done_ok  <= 1'b0;
                    r_mis_flag <= 1'b0;
                    r_err_flag <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.stall        = ((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY);
    assign bus.dw_read_data = r_rd_data;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_byte_en  = r_mem_byte_en;
    assign bus.mem_wr_data  = r_mem_wr_data;
    assign bus.misaligned   = r_mis_flag;
    assign bus.bus_error    = r_err_flag;
    assign bus.load_count   = r_load_count;
    assign bus.store_count  = r_store_count;

endmodule
`default_nettype wire

// File: tb/tb_dbus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dbus_ctrl : directed scoreboard bench for dbus_ctrl               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dbus_ctrl;
    import dbus_ctrl_pkg::*;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        err;
        int          stalls;
        int          reqs;
        logic        ok;
        logic        wr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_loads = 0;
    int   exp_stores = 0;
    exp_t sb[$];

    dbus_ctrl_if bus ();

    dbus_ctrl #(
        .DATA_BASE (32'h1001_0000),
        .DATA_SIZE (32'h0000_2000)
`ifdef DBUS_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drop_request();
        bus.dw_read_enable  = 1'b0;
        bus.dw_write_enable = 1'b0;
        bus.dw_byte_enable  = 4'b0000;
        bus.dw_address      = 32'h0;
        bus.dw_write_data   = 32'h0;
    endtask

    // waits < 0 means the memory never acknowledges
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits,
                          input logic [31:0] ack_data, input logic exp_mem,
                          input logic exp_mis, input logic exp_err);
        exp_t e;
        exp_t got;
        int   stalls = 0;
        int   reqs = 0;
        logic done = 1'b0;
        e.mis    = exp_mis;
        e.err    = exp_err;
        e.wr     = wr;
        e.ok     = !exp_mis && !exp_err;
        e.data   = (!e.ok || wr || !exp_mem) ? 32'h0 : ack_data;
        e.reqs   = !exp_mem ? 0 : (waits < 0 ? TO : waits + 1);
        e.stalls = 1 + e.reqs;
        sb.push_back(e);

        bus.dw_read_enable  = rd;
        bus.dw_write_enable = wr;
        bus.dw_byte_enable  = be;
        bus.dw_address      = addr;
        bus.dw_write_data   = wdata;
        for (int c = 0; c < 200; c++) begin
            bus.mem_ack     = 1'b0;
            bus.mem_rd_data = ~ack_data;
            #1;
            if (!bus.stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            if (bus.mem_req) begin
                reqs++;
                check({tag, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
                check({tag, "_we"}, {31'b0, bus.mem_we}, {31'b0, wr});
                check({tag, "_be"}, {28'b0, bus.mem_byte_en}, {28'b0, be});
                check({tag, "_wdata"}, bus.mem_wr_data, wdata);
                if (waits >= 0 && reqs == waits + 1) begin
                    bus.mem_ack     = 1'b1;
                    bus.mem_rd_data = ack_data;
                end
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, {31'b0, done}, 32'd1);
        got = sb.pop_front();
        check({tag, "_rdata"}, bus.dw_read_data, got.data);
        check({tag, "_mis"}, {31'b0, bus.misaligned}, {31'b0, got.mis});
        check({tag, "_err"}, {31'b0, bus.bus_error}, {31'b0, got.err});
        check({tag, "_stalls"}, stalls, got.stalls);
        check({tag, "_reqs"}, reqs, got.reqs);
        check({tag, "_req_in_done"}, {31'b0, bus.mem_req}, 32'd0);

        drop_request();
        if (got.ok) begin
            if (got.wr) exp_stores++;
            else        exp_loads++;
        end
        @(negedge clk);
        #1;
        check({tag, "_loads"}, bus.load_count, exp_loads);
        check({tag, "_stores"}, bus.store_count, exp_stores);
        check({tag, "_pulse_end"}, {30'b0, bus.misaligned, bus.bus_error}, 32'd0);
        check({tag, "_rdata_hold"}, bus.dw_read_data, got.data);
    endtask

    initial begin
        int reqs;
        logic hit;
        drop_request();
        bus.mem_ack     = 1'b0;
        bus.mem_rd_data = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        check("rst_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_rdata", bus.dw_read_data, 32'h0);
        check("rst_flags", {30'b0, bus.misaligned, bus.bus_error}, 32'd0);
        check("rst_counts", bus.load_count | bus.store_count, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        access("ld0", 1, 0, BE_WORD, 32'h1001_0004, 32'h0, 0, 32'hCAFE_F00D, 1, 0, 0);
        access("st5", 0, 1, BE_HALF_LO, 32'h1001_0010, 32'h1234_5678, 5, 32'hAAAA_5555, 1, 0, 0);
        access("ldmis", 1, 0, BE_WORD, 32'h1001_0002, 32'h0, 0, 32'h1111_1111, 0, 1, 0);
        access("stoor", 0, 1, BE_WORD, 32'h0000_0040, 32'h5555_AAAA, 0, 32'h0, 0, 0, 1);
        access("hmis", 1, 0, BE_HALF_HI, 32'h1001_0001, 32'h0, 0, 32'h0, 0, 1, 0);
        access("byte", 1, 0, 4'b0100, 32'h1001_0003, 32'h0, 2, 32'h00AB_0000, 1, 0, 0);
        access("ldlast", 1, 0, BE_WORD, 32'h1001_1FFC, 32'h0, 1, 32'h0BAD_CAFE, 1, 0, 0);
        access("ldend", 1, 0, BE_WORD, 32'h1001_2000, 32'h0, 0, 32'h0, 0, 0, 1);
        access("nop", 0, 1, BE_NONE, 32'h0000_0040, 32'hFFFF_FFFF, 0, 32'h0, 0, 0, 0);
        access("both", 1, 1, BE_WORD, 32'h1001_0008, 32'h8765_4321, 0, 32'h7777_7777, 1, 0, 0);
`ifdef DBUS_TIMEOUT_EN
        access("tmo", 1, 0, BE_WORD, 32'h1001_0030, 32'h0, -1, 32'hDEAD_BEEF, 1, 0, 1);
`endif

        // Reset in the third BUSY cycle, then a stray ack
        bus.dw_read_enable = 1'b1;
        bus.dw_byte_enable = BE_WORD;
        bus.dw_address     = 32'h1001_0020;
        reqs = 0;
        hit  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.mem_req) reqs++;
            if (reqs == 3) begin
                hit = 1'b1;
                rst = 1'b1;
                drop_request();
                break;
            end
            @(negedge clk);
        end
        check("rst_busy_reached", {31'b0, hit}, 32'd1);
        @(negedge clk);
        #1;
        check("rstmid_req", {31'b0, bus.mem_req}, 32'd0);
        check("rstmid_stall", {31'b0, bus.stall}, 32'd0);
        check("rstmid_loads", bus.load_count, 32'd0);
        check("rstmid_stores", bus.store_count, 32'd0);
        check("rstmid_rdata", bus.dw_read_data, 32'h0);
        rst = 1'b0;
        bus.mem_ack     = 1'b1;
        bus.mem_rd_data = 32'h9999_9999;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        check("late_ack_req", {31'b0, bus.mem_req}, 32'd0);
        check("late_ack_rdata", bus.dw_read_data, 32'h0);
        check("late_ack_loads", bus.load_count, 32'd0);
        exp_loads  = 0;
        exp_stores = 0;
        @(negedge clk);

        access("ldpost", 1, 0, BE_WORD, 32'h1001_0004, 32'h0, 0, 32'h0123_4567, 1, 0, 0);
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dbus_ctrl.md
Name: dbus_ctrl

Overview:
- Data-bus controller sitting directly downstream of the uniciclo datapath's data-memory port (DwReadEnable/DwWriteEnable/DwByteEnable/DwAddress/DwWriteData/DwReadData).
- Converts the datapath's single-cycle combinational access into a req/ack transaction to a variable-latency data memory.
- Raises oStall so the PC holds until the access completes.
- Filters misaligned and out-of-range accesses before they reach memory.

Parameters:
- DATA_BASE, 32'h10010000, first byte address of the data region.
- DATA_SIZE, 32'h00002000, region size in bytes; legal address range is [DATA_BASE, DATA_BASE+DATA_SIZE).
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with DBUS_TIMEOUT_EN.

Ports:
- iCLK  in  1  system clock; all state updates on rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iDwReadEnable  in  1  datapath load request.
- iDwWriteEnable  in  1  datapath store request.
- iDwByteEnable  in  4  byte lanes.
- iDwAddress  in  32  byte address.
- iDwWriteData  in  32  store data, already lane-aligned.
- oDwReadData  out  32  load data returned to the datapath.
- oStall  out  1  freeze PC / register write.
- oMemReq  out  1  memory request, held until ack.
- oMemWe  out  1  1 = write.
- oMemAddr  out  32  word address; [1:0] forced to 0.
- oMemByteEn  out  4  byte lanes.
- oMemWrData  out  32  write data.
- iMemAck  in  1  one-cycle completion strobe.
- iMemRdData  in  32  read data, valid with iMemAck.
- oMisaligned  out  1  one-cycle pulse.
- oBusError  out  1  one-cycle pulse.
- oLoadCount  out  32  completed loads.
- oStoreCount  out  32  completed stores.

Behaviour:
- Reset (iRST high at edge): state IDLE. All outputs and registers 0. Reset mid-transaction aborts it: oMemReq low the next cycle, late iMemAck ignored.
- A request is present when iDwReadEnable | iDwWriteEnable. When both are high, the access is a write.
- oStall is combinational: (state==IDLE && request present) || state==BUSY.
- FSM IDLE:
  - No request: stay IDLE.
  - Request with byte enable 4'b0000: go to DONE with no memory access. Counts as a completed load or store.
  - Word access (byte enable 4'b1111) with address[1:0] != 0: set misaligned flag, go to DONE, no memory access.
  - Halfword enables (4'b0011 or 4'b1100) with address[0] = 1: also misaligned.
  - Address outside the legal range: set error flag, go to DONE, no memory access.
  - Otherwise: register address/we/byte enable/write data, go to BUSY.
- FSM BUSY:
  - oMemReq=1; memory outputs come only from registers, stable while waiting.
  - On iMemAck: capture iMemRdData (loads only) and go to DONE.
  - iMemAck is ignored in IDLE and DONE.
- FSM DONE (exactly 1 cycle):
  - oStall=0 and oDwReadData = captured data; 0 for writes, faults and no-ops.
  - oMisaligned or oBusError pulses high this cycle if its flag is set; flags clear on exit.
  - Load or store counter increments by 1 for successful accesses only; wraps 32'hFFFFFFFF -> 0.
  - Always goes to IDLE; datapath request lines are ignored this cycle, since the same instruction is committing.
- Minimum latency: a memory that acks in the first BUSY cycle gives 2 stall cycles plus the DONE cycle; instruction retires at the end of DONE.
- oDwReadData holds its value until the next DONE.

Optional Feature:
- Macro DBUS_TIMEOUT_EN.
- Defined:
  - Wait counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop oMemReq, set error flag, go to DONE with read data 32'h00000000. An ack in the same cycle as timeout wins (normal completion).
- Undefined: BUSY waits indefinitely; no counter logic is synthesized.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), byte-enable constants (BE_WORD, BE_HALF_LO, BE_HALF_HI, BE_NONE), default region constants.
- One sub-module, dbus_access_check: combinational classification of address/byte enable into ok/misaligned/out-of-range.

Test Plan:
- Load, zero wait: address 32'h10010004, BE 1111, ack one cycle after req with 32'hCAFEF00D -> oStall high 2 cycles; DONE shows oDwReadData=32'hCAFEF00D; oLoadCount=1.
- Store, 5 wait cycles: address 32'h10010010, data 32'h12345678, BE 0011 -> oMemWe=1, oMemByteEn=0011, outputs stable 5 cycles, oStoreCount=1, no memory access while in DONE.
- Misaligned word load at 32'h10010002 -> oMemReq never rises; oMisaligned pulses in DONE; oDwReadData=0; counters unchanged.
- Out-of-range store to 32'h00000040 -> no oMemReq; oBusError pulse; stall lasts 1 cycle.
- iRST asserted in the 3rd BUSY cycle, iMemAck arriving after -> next cycle IDLE, oMemReq=0, counters 0, late ack ignored.
- With DBUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> oMemReq drops after 4 BUSY cycles; oBusError pulse; oDwReadData=0.
